// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: opcodes, ALUOp encodings and the Control bundle
// carried down the pipeline.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_hazard_pipe_hazard_detect.sv
// Load-use hazard detection between the load held in EX and the
// source registers of the instruction in ID. Purely combinational.
module hazard_detect (
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    output logic       hz_o,
    output logic       noop_o,
    output logic       stall_o,
    output logic       pcwrite_o
);

    always_comb begin
        hz_o      = ex_mem_read_i && (ex_rd_i != '0) &&
                    ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
        noop_o    = hz_o;
        stall_o   = hz_o;
        pcwrite_o = !hz_o;
    end

endmodule

// File: rtl/id_ex_hazard_pipe.sv
// ID/EX pipeline register with load-use stall and branch-flush bubble
// insertion, plus saturating stall/bubble performance counters.
module id_ex_hazard_pipe
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       ALUOp_i,
    input  logic             ALUSrc_i,
    input  logic             RegWrite_i,
    input  logic             MemtoReg_i,
    input  logic             MemRead_i,
    input  logic             MemWrite_i,
    input  logic             Branch_i,
    input  logic [XLEN-1:0]  RS1data_i,
    input  logic [XLEN-1:0]  RS2data_i,
    input  logic [XLEN-1:0]  Imm_i,
    input  logic [9:0]       Funct_i,
    input  logic [4:0]       RS1addr_i,
    input  logic [4:0]       RS2addr_i,
    input  logic [4:0]       RDaddr_i,
    input  logic             Flush_i,
    output logic             NoOp_o,
    output logic             Stall_o,
    output logic             PCWrite_o,
    output logic [1:0]       ALUOp_o,
    output logic             ALUSrc_o,
    output logic             RegWrite_o,
    output logic             MemtoReg_o,
    output logic             MemRead_o,
    output logic             MemWrite_o,
    output logic             Branch_o,
    output logic [XLEN-1:0]  RS1data_o,
    output logic [XLEN-1:0]  RS2data_o,
    output logic [XLEN-1:0]  Imm_o,
    output logic [9:0]       Funct_o,
    output logic [4:0]       RS1addr_o,
    output logic [4:0]       RS2addr_o,
    output logic [4:0]       RDaddr_o,
    output logic             Valid_o,
    output logic [CNT_W-1:0] StallCnt_o,
    output logic [CNT_W-1:0] BubbleCnt_o
);

    ctrl_t             ctrl_in;
    ctrl_t             ctrl_d, ctrl_q;
    logic              valid_d, valid_q;
    logic [XLEN-1:0]   rs1data_q, rs2data_q, imm_q;
    logic [9:0]        funct_q;
    logic [4:0]        rs1addr_q, rs2addr_q, rdaddr_q;
    logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0]  bubble_cnt_d, bubble_cnt_q;
    logic              hz, bub;

    hazard_detect u_hazard_detect (
        .ex_mem_read_i (ctrl_q.mem_read),
        .ex_rd_i       (rdaddr_q),
        .id_rs1_i      (RS1addr_i),
        .id_rs2_i      (RS2addr_i),
        .hz_o          (hz),
        .noop_o        (NoOp_o),
        .stall_o       (Stall_o),
        .pcwrite_o     (PCWrite_o)
    );

    assign ctrl_in = {ALUOp_i, ALUSrc_i, RegWrite_i, MemtoReg_i,
                      MemRead_i, MemWrite_i, Branch_i};

    // A stall already bubbles EX, so a coincident flush adds nothing.
    assign bub = hz || Flush_i;

    always_comb begin
        ctrl_d       = ctrl_in;
        valid_d      = 1'b1;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bub) begin
            ctrl_d  = CTRL_BUBBLE;
            valid_d = 1'b0;
        end
        if (hz && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (bub && (bubble_cnt_q != '1))
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_q       <= CTRL_BUBBLE;
            valid_q      <= 1'b0;
            rs1data_q    <= '0;
            rs2data_q    <= '0;
            imm_q        <= '0;
            funct_q      <= '0;
            rs1addr_q    <= '0;
            rs2addr_q    <= '0;
            rdaddr_q     <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            valid_q      <= valid_d;
            rs1data_q    <= RS1data_i;
            rs2data_q    <= RS2data_i;
            imm_q        <= Imm_i;
            funct_q      <= Funct_i;
            rs1addr_q    <= RS1addr_i;
            rs2addr_q    <= RS2addr_i;
            rdaddr_q     <= RDaddr_i;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ALUOp_o     = ctrl_q.alu_op;
    assign ALUSrc_o    = ctrl_q.alu_src;
    assign RegWrite_o  = ctrl_q.reg_write;
    assign MemtoReg_o  = ctrl_q.mem_to_reg;
    assign MemRead_o   = ctrl_q.mem_read;
    assign MemWrite_o  = ctrl_q.mem_write;
    assign Branch_o    = ctrl_q.branch;
    assign RS1data_o   = rs1data_q;
    assign RS2data_o   = rs2data_q;
    assign Imm_o       = imm_q;
    assign Funct_o     = funct_q;
    assign RS1addr_o   = rs1addr_q;
    assign RS2addr_o   = rs2addr_q;
    assign RDaddr_o    = rdaddr_q;
    assign Valid_o     = valid_q;
    assign StallCnt_o  = stall_cnt_q;
    assign BubbleCnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_pipe.sv
// Directed bench for id_ex_hazard_pipe (CNT_W=4 so counter saturation is reachable).
module tb_id_ex_hazard_pipe;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    typedef struct {
        logic [1:0]       aluop;
        logic             alusrc, regw, m2r, mr, mw, br;
        logic [XLEN-1:0]  d1, d2, imm;
        logic [9:0]       funct;
        logic [4:0]       a1, a2, rd;
        logic             valid;
        logic [CNT_W-1:0] sc, bc;
    } ex_t;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic [1:0]       ALUOp_i = '0;
    logic             ALUSrc_i = 1'b0, RegWrite_i = 1'b0, MemtoReg_i = 1'b0;
    logic             MemRead_i = 1'b0, MemWrite_i = 1'b0, Branch_i = 1'b0;
    logic [XLEN-1:0]  RS1data_i = '0, RS2data_i = '0, Imm_i = '0;
    logic [9:0]       Funct_i = '0;
    logic [4:0]       RS1addr_i = '0, RS2addr_i = '0, RDaddr_i = '0;
    logic             Flush_i = 1'b0;
    logic             NoOp_o, Stall_o, PCWrite_o;
    logic [1:0]       ALUOp_o;
    logic             ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, Branch_o;
    logic [XLEN-1:0]  RS1data_o, RS2data_o, Imm_o;
    logic [9:0]       Funct_o;
    logic [4:0]       RS1addr_o, RS2addr_o, RDaddr_o;
    logic             Valid_o;
    logic [CNT_W-1:0] StallCnt_o, BubbleCnt_o;

    int unsigned checks = 0;
    int unsigned errors = 0;
    ex_t         model;
    ex_t         sb[$];

    id_ex_hazard_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i),
        .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .Branch_i(Branch_i), .RS1data_i(RS1data_i), .RS2data_i(RS2data_i),
        .Imm_i(Imm_i), .Funct_i(Funct_i), .RS1addr_i(RS1addr_i),
        .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i), .Flush_i(Flush_i),
        .NoOp_o(NoOp_o), .Stall_o(Stall_o), .PCWrite_o(PCWrite_o),
        .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o), .RegWrite_o(RegWrite_o),
        .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
        .Branch_o(Branch_o), .RS1data_o(RS1data_o), .RS2data_o(RS2data_o),
        .Imm_o(Imm_o), .Funct_o(Funct_o), .RS1addr_o(RS1addr_o),
        .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o), .Valid_o(Valid_o),
        .StallCnt_o(StallCnt_o), .BubbleCnt_o(BubbleCnt_o)
    );

    always #10 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ex_t ins(input logic [1:0] aluop, input logic alusrc, regw, m2r,
                                mr, mw, br, input logic [4:0] a1, a2, rd);
        ex_t e;
        e.aluop = aluop; e.alusrc = alusrc; e.regw = regw; e.m2r = m2r;
        e.mr = mr; e.mw = mw; e.br = br;
        e.d1 = $urandom; e.d2 = $urandom; e.imm = $urandom;
        e.funct = 10'($urandom);
        e.a1 = a1; e.a2 = a2; e.rd = rd;
        e.valid = 1'b0; e.sc = '0; e.bc = '0;
        return e;
    endfunction

    task automatic check_ex(input string tag, input ex_t e);
        check({tag, ".ctrl"}, 128'({ALUOp_o, ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o,
              MemWrite_o, Branch_o}), 128'({e.aluop, e.alusrc, e.regw, e.m2r, e.mr, e.mw, e.br}));
        check({tag, ".data"}, 128'({RS1data_o, RS2data_o, Imm_o}), 128'({e.d1, e.d2, e.imm}));
        check({tag, ".addr"}, 128'({Funct_o, RS1addr_o, RS2addr_o, RDaddr_o}),
              128'({e.funct, e.a1, e.a2, e.rd}));
        check({tag, ".valid"}, 128'(Valid_o), 128'(e.valid));
        check({tag, ".stallcnt"}, 128'(StallCnt_o), 128'(e.sc));
        check({tag, ".bubblecnt"}, 128'(BubbleCnt_o), 128'(e.bc));
    endtask

    // Drive ID, check hazard outputs, push prediction, then compare after the edge.
    task automatic do_cycle(input string tag, input ex_t in, input logic fl);
        ex_t e, got;
        logic hz;
        ALUOp_i = in.aluop; ALUSrc_i = in.alusrc; RegWrite_i = in.regw;
        MemtoReg_i = in.m2r; MemRead_i = in.mr; MemWrite_i = in.mw; Branch_i = in.br;
        RS1data_i = in.d1; RS2data_i = in.d2; Imm_i = in.imm; Funct_i = in.funct;
        RS1addr_i = in.a1; RS2addr_i = in.a2; RDaddr_i = in.rd; Flush_i = fl;
        #1;
        hz = model.mr && (model.rd != 5'd0) && ((model.rd == in.a1) || (model.rd == in.a2));
        check({tag, ".stall"}, 128'(Stall_o), 128'(hz));
        check({tag, ".noop"}, 128'(NoOp_o), 128'(hz));
        check({tag, ".pcwrite"}, 128'(PCWrite_o), 128'(!hz));
        e = in;
        e.valid = 1'b1;
        if (hz || fl) begin
            e.aluop = 2'b00; e.alusrc = 0; e.regw = 0; e.m2r = 0;
            e.mr = 0; e.mw = 0; e.br = 0; e.valid = 1'b0;
        end
        e.sc = model.sc + ((hz && model.sc != '1) ? CNT_W'(1) : CNT_W'(0));
        e.bc = model.bc + (((hz || fl) && model.bc != '1) ? CNT_W'(1) : CNT_W'(0));
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        got = sb.pop_front();
        check_ex(tag, got);
        model = got;
    endtask

    task automatic step(input string tag, input ex_t in, input logic fl);
        @(negedge clk_i);
        do_cycle(tag, in, fl);
    endtask

    ex_t lw5, add_use5, lw0, use0, add, lw7, beq77, lwself, lw9, use9, zero_st;

    initial begin
        zero_st = ins(2'b00, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        zero_st.d1 = '0; zero_st.d2 = '0; zero_st.imm = '0; zero_st.funct = '0;
        model = zero_st;

        // Reset state, including the combinational hazard outputs.
        #5;
        check_ex("reset", zero_st);
        check("reset.pcwrite", 128'(PCWrite_o), 128'(1'b1));
        check("reset.stall", 128'(Stall_o), 128'(1'b0));
        @(negedge clk_i);
        rst_i = 1'b1;

        // Load-use on rs1.
        lw5      = ins(2'b00, 1, 1, 1, 1, 0, 0, 5'd1, 5'd0, 5'd5);
        add_use5 = ins(2'b10, 0, 1, 0, 0, 0, 0, 5'd5, 5'd2, 5'd6);
        step("lw5", lw5, 0);
        step("use5", add_use5, 0);
        step("use5_retry", add_use5, 0);

        // Load into x0 never stalls.
        lw0  = ins(2'b00, 1, 1, 1, 1, 0, 0, 5'd3, 5'd0, 5'd0);
        use0 = ins(2'b10, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd8);
        step("lw0", lw0, 0);
        step("use0", use0, 0);

        // Flush without hazard.
        add = ins(2'b10, 0, 1, 0, 0, 0, 0, 5'd4, 5'd5, 5'd9);
        step("flush", add, 1);
        step("after_flush", add, 0);

        // Flush together with a hazard on rs1==rs2==rd: one stall only.
        lw7   = ins(2'b00, 1, 1, 1, 1, 0, 0, 5'd1, 5'd0, 5'd7);
        beq77 = ins(2'b01, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd0);
        step("lw7", lw7, 0);
        step("flush_hz", beq77, 1);
        step("branch_cap", beq77, 0);

        // Back-to-back self-dependent loads stall every other cycle; counters saturate.
        lwself = ins(2'b00, 1, 1, 1, 1, 0, 0, 5'd5, 5'd5, 5'd5);
        for (int i = 0; i < 34; i++) step("sat", lwself, 0);
        check("sat.stallcnt_max", 128'(StallCnt_o), 128'(4'hF));
        check("sat.bubblecnt_max", 128'(BubbleCnt_o), 128'(4'hF));

        // Async reset asserted while a stall is being signalled.
        lw9  = ins(2'b00, 1, 1, 1, 1, 0, 0, 5'd1, 5'd0, 5'd9);
        use9 = ins(2'b10, 0, 1, 0, 0, 0, 0, 5'd9, 5'd3, 5'd10);
        step("lw9", lw9, 0);
        @(negedge clk_i);
        RS1addr_i = use9.a1; RS2addr_i = use9.a2;
        #1;
        check("midrst.stall_before", 128'(Stall_o), 128'(1'b1));
        #1;
        rst_i = 1'b0;
        #1;
        check("midrst.stall", 128'(Stall_o), 128'(1'b0));
        check("midrst.pcwrite", 128'(PCWrite_o), 128'(1'b1));
        check_ex("midrst", zero_st);
        #1;
        rst_i = 1'b1;
        model = zero_st;
        do_cycle("post_rst", use9, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
